// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the program counter, requests instruction words
// from memory and presents them to the decoder, with redirect support via R7 writes.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_inc,
    input  logic        pc_wr_en,
    input  logic [15:0] pc_wr_data,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    logic        pend;
    logic [15:0] pend_addr;
    logic [15:0] wr_target;

    // Redirect targets are forced halfword-aligned so pc bit 0 never becomes 1.
    assign wr_target = pc_wr_data & 16'hFFFE;
    assign imem_addr = pc;

    // NOTE: every register here uses <= so all next-state decisions read the
    // values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= 16'h0000;
            inst       <= 16'h0000;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (imem_ack) begin
                        if (pc_wr_en) begin
                            // A redirect on the ack edge wins over any older pending target.
                            pc   <= wr_target;
                            pend <= 1'b0;
                        end else if (pend) begin
                            pc   <= pend_addr;
                            pend <= 1'b0;
                        end else begin
                            inst       <= imem_data;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= EXEC;
                        end
                    end else if (pc_wr_en) begin
                        // Address must stay stable until ack, so park the target.
                        pend      <= 1'b1;
                        pend_addr <= wr_target;
                    end
                end

                EXEC: begin
                    if (pc_wr_en) begin
                        pc         <= wr_target;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (pc_inc) begin
                        pc         <= pc + 16'd2;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end
                end

                default: begin
                    state      <= IDLE;
                    inst_valid <= 1'b0;
                    imem_req   <= 1'b0;
                    pend       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences, and randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_inc = 1'b0;
    logic        pc_wr_en = 1'b0;
    logic [15:0] pc_wr_data = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_inc     (pc_inc),
        .pc_wr_en   (pc_wr_en),
        .pc_wr_data (pc_wr_data),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inc;
        logic        wr_en;
        logic [15:0] wr_data;
        logic        ack;
        logic [15:0] data;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] inst;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic inc, input logic wr_en, input logic [15:0] wr_data,
                         input logic ack, input logic [15:0] data);
        pc_inc     = inc;
        pc_wr_en   = wr_en;
        pc_wr_data = wr_data;
        imem_ack   = ack;
        imem_data  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [15:0] addr,
                              input logic valid, input logic [15:0] exp_inst,
                              input logic [15:0] exp_pc);
        check({tag, ".imem_req"}, {15'd0, imem_req}, {15'd0, req});
        if (req) check({tag, ".imem_addr"}, imem_addr, addr);
        check({tag, ".inst_valid"}, {15'd0, inst_valid}, {15'd0, valid});
        check({tag, ".inst"}, inst, exp_inst);
        check({tag, ".pc"}, pc, exp_pc);
    endtask

    // Holds reset across two edges, checks the reset state, releases it just after an edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        #1;
        check("post_release.imem_req", {15'd0, imem_req}, 16'h0000);
    endtask

    // Reference model state: mode 0 = idle, 1 = fetching, 2 = executing; pend < 0 means none.
    int m_mode;
    int m_pc;
    int m_inst;
    int m_pend;

    function automatic int align(input int v);
        return (v / 2) * 2;
    endfunction

    task automatic model_step(input bit inc, input bit wr_en, input int wr_data,
                              input bit ack, input int data);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (ack && wr_en) begin
                m_pc   = align(wr_data);
                m_pend = -1;
            end else if (ack && m_pend >= 0) begin
                m_pc   = m_pend;
                m_pend = -1;
            end else if (ack) begin
                m_inst = data;
                m_mode = 2;
            end else if (wr_en) begin
                m_pend = align(wr_data);
            end
        end else begin
            if (wr_en) begin
                m_pc   = align(wr_data);
                m_mode = 1;
            end else if (inc) begin
                m_pc   = (m_pc + 2) % 65536;
                m_mode = 1;
            end
        end
    endtask

    initial begin
        // Directed table from reset: zero-wait fetch, stalls, redirect priority, wrap.
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A48, 1'b0, 16'h0000, 1'b1, 16'h0A48, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0A48, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0002, 1'b1, 16'h1111, 16'h0002};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h1111, 16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0004};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0004};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0004};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b0, 16'h2222, 16'h0006};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 16'h0006, 1'b1, 16'h3333, 16'h0006};
        vecs[10] = '{1'b1, 1'b1, 16'h0021, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h3333, 16'h0020};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b0, 16'h0020, 1'b1, 16'h4444, 16'h0020};
        vecs[12] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h4444, 16'hFFFE};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0, 16'hFFFE, 1'b1, 16'h5555, 16'hFFFE};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h5555, 16'h0000};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h5555, 16'h0000};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666, 1'b0, 16'h0000, 1'b1, 16'h6666, 16'h0000};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].inc, vecs[i].wr_en, vecs[i].wr_data, vecs[i].ack, vecs[i].data);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                       vecs[i].inst, vecs[i].pc);
        end

        // Redirect during a slow fetch at 0x0008: address holds, acked data dropped, refetch.
        do_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A48); tick();
        drive(1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000); tick();
        check_outs("slow.start", 1'b1, 16'h0008, 1'b0, 16'h0A48, 16'h0008);
        drive(1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000); tick();
        check_outs("slow.wait1", 1'b1, 16'h0008, 1'b0, 16'h0A48, 16'h0008);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        check_outs("slow.wait2", 1'b1, 16'h0008, 1'b0, 16'h0A48, 16'h0008);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        check_outs("slow.wait3", 1'b1, 16'h0008, 1'b0, 16'h0A48, 16'h0008);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD); tick();
        check_outs("slow.discard", 1'b1, 16'h0030, 1'b0, 16'h0A48, 16'h0030);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF); tick();
        check_outs("slow.refetch", 1'b0, 16'h0030, 1'b1, 16'hBEEF, 16'h0030);

        // Two redirects while waiting: the later target wins.
        drive(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000); tick();
        drive(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000); tick();
        drive(1'b0, 1'b1, 16'h0301, 1'b0, 16'h0000); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA); tick();
        check_outs("lastwins", 1'b1, 16'h0300, 1'b0, 16'hBEEF, 16'h0300);

        // Asynchronous reset mid-fetch, then a late ack in IDLE must be ignored.
        #3;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        tick();
        check_outs("late_ack", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234); tick();
        check_outs("after_rst_fetch", 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0000);

        // Randomized traffic against the reference model.
        do_reset();
        m_mode = 0;
        m_pc   = 0;
        m_inst = 0;
        m_pend = -1;
        for (int n = 0; n < 3000; n++) begin
            bit r_inc;
            bit r_wr;
            bit r_ack;
            int r_wd;
            int r_d;
            r_inc = 1'($urandom_range(0, 1));
            r_wr  = ($urandom_range(0, 7) == 0);
            r_ack = ($urandom_range(0, 2) != 0);
            r_wd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF))
                                                : int'($urandom_range(0, 16'hFFFF));
            r_d   = int'($urandom_range(0, 16'hFFFF));
            drive(r_inc, r_wr, 16'(r_wd), r_ack, 16'(r_d));
            model_step(r_inc, r_wr, r_wd, r_ack, r_d);
            tick();
            check_outs($sformatf("rand%0d", n), (m_mode == 1), 16'(m_pc), (m_mode == 2),
                       16'(m_inst), 16'(m_pc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port pc_inc  input  1  from the decoder; 1 = advance to the next instruction, 0 = hold the current instruction for another cycle.
REQ-004 SHALL have port pc_wr_en  input  1  redirect strobe, asserted when the register file writes R7.
REQ-005 SHALL have port pc_wr_data  input  16  redirect target byte address.
REQ-006 SHALL have port imem_ack  input  1  instruction memory data valid, sampled at the clock edge.
REQ-007 SHALL have port imem_data  input  16  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port imem_req  output  1  fetch request.
REQ-009 SHALL have port imem_addr  output  16  fetch byte address.
REQ-010 SHALL have port inst  output  16  instruction presented to the decoder.
REQ-011 SHALL have port inst_valid  output  1  inst holds a freshly fetched word.
REQ-012 SHALL have port pc  output  16  byte address of the instruction in inst (or being fetched).

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, FETCH, EXEC.
REQ-014 IDLE SHALL move unconditionally to FETCH on the next clock edge.
REQ-015 In FETCH: imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-016 In FETCH: imem_addr SHALL be held stable until an edge where imem_ack=1.
REQ-017 In IDLE and EXEC, imem_req SHALL be 0.
REQ-018 FETCH, edge with imem_ack=1 and no pending redirect: inst SHALL load imem_data, inst_valid SHALL go to 1, and the FSM SHALL go to EXEC.
REQ-019 An acknowledge arriving in the same cycle as the request SHALL be legal; the minimum fetch latency SHALL be 1 cycle from imem_req rising to inst_valid rising.
REQ-020 EXEC: inst and pc SHALL be held stable.
REQ-021 EXEC, pc_wr_en=1: pc SHALL load {pc_wr_data[15:1],1'b0}, inst_valid SHALL go to 0, and the FSM SHALL go to FETCH.
REQ-022 EXEC, pc_wr_en=0 and pc_inc=1: pc SHALL load pc+2, inst_valid SHALL go to 0, and the FSM SHALL go to FETCH.
REQ-023 EXEC, pc_wr_en=0 and pc_inc=0: the FSM SHALL stay in EXEC with all outputs unchanged (second cycle of BEQ/JAL).
REQ-024 When pc_wr_en and pc_inc are both 1, the redirect SHALL have priority and pc+2 SHALL be discarded.
REQ-025 FETCH with pc_wr_en=1 and imem_ack=0: the target SHALL be captured in a pending register and the pending flag set.
REQ-026 While the pending flag is set, imem_addr SHALL NOT change until ack.
REQ-027 FETCH, edge with imem_ack=1 and the pending flag set: imem_data SHALL be discarded, pc SHALL load the pending target, the pending flag SHALL clear, and the FSM SHALL stay in FETCH (refetch).
REQ-028 FETCH, pc_wr_en=1 on the same edge as imem_ack=1: this SHALL be treated as a pending redirect, i.e. data discarded and pc loads pc_wr_data.
REQ-029 A later pc_wr_en while a redirect is pending SHALL overwrite the pending target (last write wins).
REQ-030 pc arithmetic SHALL be modulo 2^16: 16'hFFFE + 2 SHALL give 16'h0000.
REQ-031 pc bit 0 SHALL always be 0.
REQ-032 inst_valid SHALL be 1 only in EXEC.
REQ-033 pc_inc SHALL be ignored outside EXEC.

Reset
REQ-034 rst=1 SHALL force the following immediately, regardless of clk: state=IDLE, pc=16'h0000, inst=16'h0000, inst_valid=0, imem_req=0, pending flag=0.
REQ-035 rst asserted mid-fetch SHALL abandon the request; a late imem_ack after reset release SHALL be ignored unless the FSM is in FETCH.
REQ-036 After rst falls, the first imem_req SHALL appear after exactly one rising clock edge (IDLE -> FETCH).

Verification
REQ-037 Reset release, zero-wait memory returning 16'h0A48 at address 0 -> imem_req=1 with addr 16'h0000 in cycle 1, inst=16'h0A48 and inst_valid=1 in cycle 2.
REQ-038 In EXEC with pc=16'h0004, pc_inc=0 for 2 cycles then 1 -> inst held 2 cycles, then imem_addr=16'h0006.
REQ-039 In EXEC with pc_wr_en=1, pc_wr_data=16'h0021 and pc_inc=1 -> pc=16'h0020 and the next fetch is at 16'h0020.
REQ-040 In FETCH at 16'h0008, ack delayed 3 cycles, pc_wr_en=1 with data 16'h0030 in wait cycle 1 -> addr stays 16'h0008 until ack, that data is discarded, then a fetch at 16'h0030.
REQ-041 pc=16'hFFFE, pc_inc=1 -> next imem_addr=16'h0000.
REQ-042 rst pulsed while imem_req=1 -> outputs reset immediately (asynchronously); the next imem_req is at 16'h0000.
